// File: rtl/bool_burst_packer.sv
// bool_burst_packer: packs up to three consecutive Boolean symbols per encoder cycle,
// issues CDF symbols alone and sequences the frame-end flush and encoder reset.
module bool_burst_packer #(
   parameter int RANGE_WIDTH  = 16,
   parameter int SYMBOL_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    bool_burst_1,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_bool,
   input  logic [RANGE_WIDTH-1:0]  in_fl,
   input  logic [RANGE_WIDTH-1:0]  in_fh,
   input  logic [SYMBOL_WIDTH-1:0] in_symbol,
   input  logic [SYMBOL_WIDTH:0]   in_nsyms,
   input  logic                    in_frame_end,
   output logic                    enc_valid,
   output logic                    enc_flag_first,
   output logic                    enc_final_flag,
   output logic                    enc_reset,
   output logic [RANGE_WIDTH-1:0]  enc_fl,
   output logic [RANGE_WIDTH-1:0]  enc_fh,
   output logic [SYMBOL_WIDTH:0]   enc_nsyms,
   output logic [SYMBOL_WIDTH-1:0] enc_symbol_1,
   output logic [SYMBOL_WIDTH-1:0] enc_symbol_2,
   output logic [SYMBOL_WIDTH-1:0] enc_symbol_3,
   output logic                    enc_bool_1,
   output logic                    enc_bool_2,
   output logic                    enc_bool_3,
   input  logic                    enc_flag_last
);
   typedef enum logic [1:0] {RST, COLLECT, FLUSH} state_t;
   state_t r_state, w_next;
   logic [1:0]                   r_bcnt;
   logic [1:0][SYMBOL_WIDTH-1:0] r_bsym;
   logic [RANGE_WIDTH-1:0]       r_bfl, r_bfh, r_hfl, r_hfh, r_fl, r_fh, w_fl, w_fh;
   logic [SYMBOL_WIDTH:0]        r_bns, r_hns, r_ns, w_ns;
   logic                         r_hv, r_hend;
   logic [SYMBOL_WIDTH-1:0]      r_hsym;
   logic                         r_valid, r_first_out, r_first_pend;
   logic [2:0][SYMBOL_WIDTH-1:0] r_sym, w_sym, w_ent;
   logic [2:0]                   r_bool, w_bool, w_used;
   logic [1:0]                   w_n;
   logic                         w_acc, w_iss, w_end, w_cdf, w_app, w_load_h;

   assign in_ready       = (r_state == COLLECT) && !r_hv;
   assign w_acc          = in_valid && in_ready;
   assign enc_reset      = (r_state == RST);
   assign enc_final_flag = (r_state == FLUSH) && !r_valid;
   assign enc_valid      = r_valid;
   assign enc_flag_first = r_first_out;
   assign enc_fl         = r_fl;
   assign enc_fh         = r_fh;
   assign enc_nsyms      = r_ns;
   assign enc_symbol_1   = r_sym[0];
   assign enc_symbol_2   = r_sym[1];
   assign enc_symbol_3   = r_sym[2];
   assign enc_bool_1     = r_bool[0];
   assign enc_bool_2     = r_bool[1];
   assign enc_bool_3     = r_bool[2];

   always_comb begin
      w_iss    = 1'b0;
      w_end    = 1'b0;
      w_cdf    = 1'b0;
      w_app    = 1'b0;
      w_load_h = 1'b0;
      if (r_state == COLLECT) begin
         if (r_hv) begin
            w_iss = 1'b1;
            w_cdf = 1'b1;
            w_end = r_hend;
         end else if (w_acc && in_bool) begin
            w_iss    = 1'b1;
            w_cdf    = (r_bcnt == 2'd0);
            w_load_h = (r_bcnt != 2'd0);
            w_end    = in_frame_end && (r_bcnt == 2'd0);
         end else if (w_acc) begin
            w_app = 1'b1;
            w_iss = (r_bcnt == 2'd2) || in_frame_end;
            w_end = in_frame_end;
         end else begin
            w_iss = (r_bcnt != 2'd0);
         end
      end
      // entry at index r_bcnt is the symbol being appended this cycle, if any
      w_n         = r_bcnt + {1'b0, w_app};
      w_used      = {w_n == 2'd3, w_n >= 2'd2, w_n != 2'd0};
      w_ent       = {in_symbol, r_bsym};
      w_ent[r_bcnt] = in_symbol;
      for (int k = 0; k < 3; k++) begin
         w_sym[k]  = w_used[k] ? w_ent[k] : '0;
         w_bool[k] = !w_used[k];
      end
      w_fl = (r_bcnt == 2'd0) ? in_fl : r_bfl;
      w_fh = (r_bcnt == 2'd0) ? in_fh : r_bfh;
      w_ns = (r_bcnt == 2'd0) ? in_nsyms : r_bns;
      if (w_cdf) begin
         w_sym    = '0;
         w_sym[0] = r_hv ? r_hsym : in_symbol;
         w_bool   = 3'b111;
         w_fl     = r_hv ? r_hfl : in_fl;
         w_fh     = r_hv ? r_hfh : in_fh;
         w_ns     = r_hv ? r_hns : in_nsyms;
      end
      w_next = (r_state == RST) ? COLLECT :
               (r_state == FLUSH) ? (enc_flag_last ? RST : FLUSH) :
               (w_iss && w_end) ? FLUSH : COLLECT;
   end

   always_ff @(posedge clk or posedge bool_burst_1) begin
      if (bool_burst_1) r_state <= RST;
      else              r_state <= w_next;
   end

   always_ff @(posedge clk or posedge bool_burst_1) begin
      if (bool_burst_1) begin
         r_valid      <= 1'b0;
         r_first_out  <= 1'b0;
         r_first_pend <= 1'b1;
         r_sym        <= '0;
         r_bool       <= 3'b111;
         r_fl         <= '0;
         r_fh         <= '0;
         r_ns         <= '0;
         r_bcnt       <= '0;
         r_bsym       <= '0;
         r_bfl        <= '0;
         r_bfh        <= '0;
         r_bns        <= '0;
         r_hv         <= 1'b0;
         r_hend       <= 1'b0;
         r_hsym       <= '0;
         r_hfl        <= '0;
         r_hfh        <= '0;
         r_hns        <= '0;
      end else begin
         r_valid      <= w_iss;
         r_first_out  <= w_iss && r_first_pend;
         r_first_pend <= (r_state == RST) || (r_first_pend && !w_iss);
         if (w_iss) begin
            r_sym  <= w_sym;
            r_bool <= w_bool;
            r_fl   <= w_fl;
            r_fh   <= w_fh;
            r_ns   <= w_ns;
         end
         r_bcnt <= w_iss ? 2'd0 : r_bcnt + {1'b0, w_app};
         if (w_app) r_bsym[r_bcnt[0]] <= in_symbol;
         if (w_app && r_bcnt == 2'd0) begin
            r_bfl <= in_fl;
            r_bfh <= in_fh;
            r_bns <= in_nsyms;
         end
         r_hv <= w_load_h;
         if (w_load_h) begin
            r_hend <= in_frame_end;
            r_hsym <= in_symbol;
            r_hfl  <= in_fl;
            r_hfh  <= in_fh;
            r_hns  <= in_nsyms;
         end
      end
   end
endmodule
